// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register addresses and edge-type encodings.
package pio_pkg;

  // Register map (word addresses on the s1 slave)
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Capture edge selection
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronizer plus edge detector for the input PIO.
// SYNC_STAGES flops bring in_port into the clk domain (in_sync); one more flop
// holds the previous synchronized value (in_d). edge_pulse is combinational
// from those two flops and is high for exactly one cycle per detected edge.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALLING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_d;

  // Synchronizer chain: stage 0 samples the pin, last stage is in_sync
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Delayed copy of in_sync used for edge comparison
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d <= '0;
    end else begin
      in_d <= in_sync;
    end
  end

  // Edge polarity is fixed at elaboration time
  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rising
      assign edge_pulse = in_sync & ~in_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign edge_pulse = ~in_sync & in_d;
    end else begin : g_any
      assign edge_pulse = in_sync ^ in_d;
    end
  endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with sticky edge capture and masked level interrupt.
// Optional build macro: PIO_BIT_CLEAR_EN -- when defined, a write to
// EDGE_CAPTURE clears only the bits written as 1; otherwise any write to
// EDGE_CAPTURE clears every bit.
//
// Bus handshake: there is no waitrequest. A write is accepted on every clk
// edge where chipselect & ~write_n is high. Reads are always accepted with no
// side effects: readdata is registered from the address mux every cycle, so
// data for an address appears one cycle after that address is presented.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALLING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             mask_we;
  logic             edge_we;
  logic             unused_wdata;

  // Upper writedata bits are unused when WIDTH < 32
  assign unused_wdata = ^writedata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  assign wr_en   = chipselect & ~write_n;
  assign mask_we = wr_en && (address == ADDR_MASK);
  assign edge_we = wr_en && (address == ADDR_EDGE);

  // Bits to clear in edge_capture this cycle
  always_comb begin
    edge_clr = '0;
    if (edge_we) begin
`ifdef PIO_BIT_CLEAR_EN
      edge_clr = writedata[WIDTH-1:0];
`else
      edge_clr = '1;
`endif
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (mask_we) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture; a new edge overrides a clear on the same bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_pulse;
    end
  end

  // Read mux: unused addresses and upper bits return zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = in_sync;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  // Level interrupt straight from register state
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq (WIDTH=4, falling edge, 2 sync stages).
module tb_pio_in_edge_irq;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  pio_in_edge_irq #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (1),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // All stimulus is applied 1 time unit after a rising edge and outputs are
  // sampled at the same point, after the edge has settled.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick(1);
    data = readdata;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    bus_read(addr, got);
    check(name, got, exp_q.pop_front());
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  in_val;
    logic [3:0]  mask;
    logic [31:0] exp_edge;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] exp_clr;

    // Each vector follows the previous input value; falling edges only.
    vecs[0] = '{4'h4, 4'h1, 32'h1, 1'b1};  // 5->4: bit0 falls, masked in
    vecs[1] = '{4'h6, 4'h1, 32'h0, 1'b0};  // bit1 rises only
    vecs[2] = '{4'h4, 4'h1, 32'h2, 1'b0};  // bit1 falls, masked out
    vecs[3] = '{4'h0, 4'h4, 32'h4, 1'b1};  // bit2 falls
    vecs[4] = '{4'hF, 4'hF, 32'h0, 1'b0};  // all rise
    vecs[5] = '{4'h0, 4'h8, 32'hF, 1'b1};  // all fall
    vecs[6] = '{4'hA, 4'hF, 32'h0, 1'b0};  // rises only
    vecs[7] = '{4'h5, 4'h2, 32'hA, 1'b1};  // bits 3,1 fall
    vecs[8] = '{4'h5, 4'h5, 32'h0, 1'b0};  // no change

    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    reset_n    = 1'b0;

    // Reset with inputs high
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    in_port = 4'h0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    read_check("post_reset_data", 2'd0, 32'h0);
    read_check("post_reset_edge", 2'd3, 32'h0);
    read_check("post_reset_mask", 2'd2, 32'h0);

    // Sync latency: 0 -> 5, address held at DATA
    address = 2'd0;
    tick(1);
    in_port = 4'h5;
    tick(1);
    check("sync_lat_t1", readdata, 32'h0);
    tick(1);
    check("sync_lat_t2", readdata, 32'h0);
    tick(1);
    check("sync_lat_t3", readdata, 32'h5);
    tick(1);
    check("sync_lat_t4", readdata, 32'h5);
    read_check("rising_not_captured", 2'd3, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    read_check("reserved_reads_zero", 2'd1, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    read_check("data_write_ignored", 2'd0, 32'h5);

    // Table-driven edge / irq vectors
    for (int i = 0; i < 9; i++) begin
      bus_write(2'd2, {28'h0, vecs[i].mask});
      read_check($sformatf("vec%0d_mask", i), 2'd2, {28'h0, vecs[i].mask});
      in_port = vecs[i].in_val;
      tick(4);
      read_check($sformatf("vec%0d_data", i), 2'd0, {28'h0, vecs[i].in_val});
      read_check($sformatf("vec%0d_edge", i), 2'd3, vecs[i].exp_edge);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      bus_write(2'd3, 32'hF);
      check($sformatf("vec%0d_irq_clr", i), {31'h0, irq}, 32'h0);
      read_check($sformatf("vec%0d_edge_clr", i), 2'd3, 32'h0);
    end

    // Mask change updates irq in the same cycle as the mask write
    bus_write(2'd2, 32'h0);
    in_port = 4'h4;                      // bit0 falls
    tick(4);
    check("mask_off_irq", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    check("mask_on_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h0);
    check("mask_off_again_irq", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'hF);

    // Clear collision: bit2 already captured, bit0 edge lands with the clear
    bus_write(2'd2, 32'h1);
    in_port = 4'h5;
    tick(4);
    in_port = 4'h1;                      // bit2 falls
    tick(4);
    read_check("collide_pre_edge", 2'd3, 32'h4);
    in_port = 4'h0;                      // bit0 falls
    tick(2);                             // edge pulse now high
    bus_write(2'd3, 32'hF);              // clear lands on the capture edge
    check("collide_irq", {31'h0, irq}, 32'h1);
    read_check("collide_edge", 2'd3, 32'h1);
    bus_write(2'd3, 32'hF);
    check("collide_irq_cleared", {31'h0, irq}, 32'h0);

    // Partial clear: EDGE_CAPTURE=0x3, write 0x1
    in_port = 4'h3;
    tick(4);
    in_port = 4'h0;
    tick(4);
    read_check("partial_pre", 2'd3, 32'h3);
    bus_write(2'd3, 32'h1);
`ifdef PIO_BIT_CLEAR_EN
    exp_clr = 32'h2;
`else
    exp_clr = 32'h0;
`endif
    read_check("partial_clear", 2'd3, exp_clr);
    bus_write(2'd3, 32'hF);

    // Reset mid-operation, asynchronous pulse between clock edges
    in_port = 4'hF;
    tick(4);
    in_port = 4'h0;
    tick(4);
    bus_write(2'd2, 32'hF);
    read_check("midrst_edge_pre", 2'd3, 32'hF);
    check("midrst_irq_pre", {31'h0, irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_irq_async", {31'h0, irq}, 32'h0);
    check("midrst_readdata_async", readdata, 32'h0);
    #1;
    reset_n = 1'b1;
    tick(1);
    read_check("midrst_edge_post", 2'd3, 32'h0);
    read_check("midrst_mask_post", 2'd2, 32'h0);
    read_check("midrst_data_post", 2'd0, 32'h0);
    check("midrst_irq_post", {31'h0, irq}, 32'h0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
